// File: rtl/seq_scan_ctrl.sv
// Frame-based serial pattern scanner: latches a programmable pattern on start,
// scans a fixed number of qualified bits and reports hits with a saturating count.
module seq_scan_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int FRM_W   = 16,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [FRM_W-1:0]   cfg_frame,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               busy,
  output logic               match,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic               sat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Ones in the low len positions; only those history bits take part in a compare.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(len));
    return m;
  endfunction

  logic [1:0]         state, state_nxt;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] mask_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [FRM_W-1:0]   rem_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;
  logic               match_q;

  logic [LEN_W-1:0]   len_clamp;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W:0]     fill_p1;
  logic               accept;
  logic               scan_bit;
  logic               last_bit;
  logic               hit;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end
  end

  assign accept   = (state == ST_IDLE) && start;
  assign scan_bit = (state == ST_SCAN) && bit_valid;
  assign last_bit = scan_bit && (rem_q == FRM_W'(1));
  assign hist_nxt = {hist_q[MAX_LEN-2:0], bit_in};
  assign fill_p1  = {1'b0, fill_q} + (LEN_W + 1)'(1);

  // fill counts bits gathered since start or since the last non-overlapping hit,
  // so stale history contents never produce a hit on their own.
  assign hit = scan_bit
            && (fill_p1 >= {1'b0, len_q})
            && (((hist_nxt ^ pat_q) & mask_q) == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (cfg_frame == '0) ? ST_DONE : ST_SCAN;
      ST_SCAN: if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pat_q   <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      rem_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      match_q <= hit;
      if (accept) begin
        pat_q  <= cfg_pattern;
        mask_q <= len_mask(len_clamp);
        len_q  <= len_clamp;
        ovl_q  <= cfg_overlap;
        rem_q  <= cfg_frame;
        hist_q <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
        sat_q  <= 1'b0;
      end else if (scan_bit) begin
        hist_q <= hist_nxt;
        rem_q  <= rem_q - FRM_W'(1);
        if (hit && !ovl_q) begin
          fill_q <= '0;
        end else if (fill_q != LEN_MAX) begin
          fill_q <= fill_q + LEN_W'(1);
        end
        if (hit) begin
          if (cnt_q == CNT_MAX) begin
            sat_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign match       = match_q;
  assign match_count = cnt_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: vector table plus hand-written corner sequences
// (saturation on a 2-bit counter instance, stalls with ignored start, mid-frame reset).
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [15:0] cfg_frame = '0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;

  logic       busy, match, done, sat;
  logic [7:0] match_count;
  logic       s_busy, s_match, s_done, s_sat;
  logic [1:0] s_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_frame(cfg_frame), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy), .match(match), .done(done), .match_count(match_count), .sat(sat)
  );

  seq_scan_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_frame(cfg_frame), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(s_busy), .match(s_match), .done(s_done), .match_count(s_count), .sat(s_sat)
  );

  typedef struct {
    logic        start;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic [15:0] frame;
    logic        bv;
    logic        bi;
    logic        em;
    logic        ed;
    logic        eb;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[$];
  logic [7:0]  t_pat;
  logic [3:0]  t_len;
  logic        t_ovl;
  logic [15:0] t_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [15:0] f);
    t_pat = p; t_len = l; t_ovl = o; t_frame = f;
  endtask

  task automatic add(input logic s, input logic bv, input logic bi,
                     input logic em, input logic ed, input logic eb, input logic [7:0] ec);
    vec_t e;
    e.start = s; e.pat = t_pat; e.len = t_len; e.ovl = t_ovl; e.frame = t_frame;
    e.bv = bv; e.bi = bi; e.em = em; e.ed = ed; e.eb = eb; e.ec = ec;
    tbl.push_back(e);
  endtask

  // Pattern 1101, len 4, frame 7, stream 1101101.
  task automatic add_scen1(input logic ovl);
    cfg(8'h0D, 4'd4, ovl, 16'd7);
    add(1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 1, 1);
    add(0, 1, 1, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 1);
    if (ovl) add(0, 1, 1, 1, 1, 1, 2);
    else     add(0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, ovl ? 8'd2 : 8'd1);
  endtask

  task automatic drive(input logic s, input logic bv, input logic bi);
    start = s; bit_valid = bv; bit_in = bi;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; cfg_pattern = tbl[i].pat; cfg_len = tbl[i].len;
      cfg_overlap = tbl[i].ovl; cfg_frame = tbl[i].frame;
      drive(tbl[i].start, tbl[i].bv, tbl[i].bi);
      check($sformatf("tbl[%0d].match", i), 32'(match), 32'(tbl[i].em));
      check($sformatf("tbl[%0d].done", i), 32'(done), 32'(tbl[i].ed));
      check($sformatf("tbl[%0d].busy", i), 32'(busy), 32'(tbl[i].eb));
      check($sformatf("tbl[%0d].count", i), 32'(match_count), 32'(tbl[i].ec));
    end
    tbl.delete();
  endtask

  initial begin
    logic s1 [7] = '{1, 1, 0, 1, 1, 0, 1};
    logic e1 [7] = '{0, 0, 0, 1, 0, 0, 1};
    int n_match;
    int n_done;

    @(negedge clk);
    @(negedge clk);
    check("reset.busy", 32'(busy), 0);
    check("reset.match", 32'(match), 0);
    check("reset.done", 32'(done), 0);
    check("reset.count", 32'(match_count), 0);
    check("reset.sat", 32'(sat), 0);
    rst = 1'b0;

    add_scen1(1'b1);
    add_scen1(1'b0);
    // Empty frame: done immediately, count cleared from previous frame.
    cfg(8'h0D, 4'd4, 1'b1, 16'd0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // Length 0 behaves as length 1; stream 101.
    cfg(8'h01, 4'd0, 1'b1, 16'd3);
    add(1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 1, 1, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 2);
    // Length 15 clamps to 8: pattern A5 found only on bit 9 of 010100101.
    cfg(8'hA5, 4'd15, 1'b1, 16'd9);
    add(1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    run_table();

    // Saturation on the 2-bit counter instance: five hits, count stops at 3.
    cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1; cfg_frame = 16'd5;
    drive(1, 0, 0);
    check("sat.start.count", 32'(s_count), 0);
    check("sat.start.sat", 32'(s_sat), 0);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 1);
      check($sformatf("sat.bit%0d.match", i), 32'(s_match), 1);
      check($sformatf("sat.bit%0d.count", i), 32'(s_count), (i > 3) ? 3 : i);
      check($sformatf("sat.bit%0d.sat", i), 32'(s_sat), (i >= 4) ? 1 : 0);
      check($sformatf("sat.bit%0d.done", i), 32'(s_done), (i == 5) ? 1 : 0);
      check($sformatf("sat.bit%0d.wide_count", i), 32'(match_count), i);
    end
    drive(0, 0, 0);
    check("sat.hold.busy", 32'(s_busy), 0);
    check("sat.hold.count", 32'(s_count), 3);
    check("sat.hold.sat", 32'(s_sat), 1);
    cfg_frame = 16'd0;
    drive(1, 0, 0);
    check("sat.restart.sat", 32'(s_sat), 0);
    check("sat.restart.count", 32'(s_count), 0);
    drive(0, 0, 0);

    // Random stalls; a start with garbage config during the frame must be ignored.
    cfg_pattern = 8'h0D; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_frame = 16'd7;
    drive(1, 0, 0);
    cfg_pattern = 8'hFF; cfg_len = 4'd1; cfg_overlap = 1'b0; cfg_frame = 16'd2;
    n_match = 0;
    n_done = 0;
    for (int i = 0; i < 7; i++) begin
      int gap;
      gap = (i == 2) ? 1 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        drive((i == 2) && (g == 0), 0, 1'($urandom));
        check($sformatf("gap.b%0d.g%0d.match", i, g), 32'(match), 0);
        check($sformatf("gap.b%0d.g%0d.busy", i, g), 32'(busy), 1);
        check($sformatf("gap.b%0d.g%0d.done", i, g), 32'(done), 0);
      end
      drive(0, 1, s1[i]);
      check($sformatf("gap.bit%0d.match", i + 1), 32'(match), 32'(e1[i]));
      check($sformatf("gap.bit%0d.done", i + 1), 32'(done), (i == 6) ? 1 : 0);
      if (match) n_match++;
      if (done) n_done++;
    end
    drive(0, 0, 0);
    check("gap.count", 32'(match_count), 2);
    check("gap.matches", 32'(n_match), 2);
    check("gap.dones", 32'(n_done), 1);
    check("gap.busy_after", 32'(busy), 0);

    // Reset three bits into a seven-bit frame abandons it without done.
    cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1; cfg_frame = 16'd7;
    drive(1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1);
    check("rst.pre.count", 32'(match_count), 3);
    check("rst.pre.match", 32'(match), 1);
    rst = 1'b1;
    drive(0, 1, 1);
    check("rst.busy", 32'(busy), 0);
    check("rst.match", 32'(match), 0);
    check("rst.done", 32'(done), 0);
    check("rst.count", 32'(match_count), 0);
    check("rst.sat", 32'(sat), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1);
      check($sformatf("rst.after%0d.done", i), 32'(done), 0);
      check($sformatf("rst.after%0d.busy", i), 32'(busy), 0);
      check($sformatf("rst.after%0d.match", i), 32'(match), 0);
    end
    add_scen1(1'b1);
    run_table();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-based controller for serial pattern detection: on a `start` handshake it latches a programmable pattern (1..MAX_LEN bits), length, overlap mode and frame length. It then scans exactly `cfg_frame` valid serial bits, pulsing `match` on every pattern hit and counting hits with saturation. It generalises the fixed 1101 Mealy detector into a configurable, software-sequenced scan engine on the serial input path.

## Interface
- `MAX_LEN`, 8, maximum pattern length in bits (2..16)
- `CNT_W`, 8, width of match counter
- `FRM_W`, 16, width of frame-length field
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a scan; accepted only in IDLE
- `cfg_pattern`  in  MAX_LEN  pattern; bit `[len-1]` is first-received, bit `[0]` last-received
- `cfg_len`  in  $clog2(MAX_LEN+1)  pattern length; 0 treated as 1, >MAX_LEN treated as MAX_LEN
- `cfg_overlap`  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
- `cfg_frame`  in  FRM_W  number of valid bits to scan
- `bit_in`  in  1  serial data
- `bit_valid`  in  1  `bit_in` qualifier; bits ignored outside SCAN
- `busy`  out  1  high when state != IDLE
- `match`  out  1  one-cycle pulse, registered
- `done`  out  1  one-cycle pulse at end of frame
- `match_count`  out  CNT_W  hits in current/last frame
- `sat`  out  1  sticky: counter saturated this frame

## Operation
- States: IDLE, SCAN, DONE.
- IDLE + `start`:
  - Latch `cfg_*` (clamped length).
  - Clear history shift register, fill counter, `match_count` and `sat`.
  - Load remaining = `cfg_frame`.
  - Go to SCAN, or to DONE if `cfg_frame`==0.
- SCAN + `bit_valid`:
  - Shift history: `hist <= {hist[MAX_LEN-2:0], bit_in}`.
  - Increment fill (saturating at MAX_LEN).
  - Decrement remaining.
- Hit condition: `(fill+1) >= len` and low `len` bits of the new history equal low `len` bits of the latched pattern.
- On hit:
  - `match` pulses next cycle.
  - `match_count` increments; if already at 2^CNT_W-1 it holds and `sat` sets.
  - If overlap==0, fill resets to 0 (the history contents may remain, since fill gates detection).
- SCAN with `bit_valid`=0: no state change; stalls have unlimited length.
- The last frame bit (remaining 1->0) moves SCAN to DONE. DONE lasts exactly one cycle, then returns to IDLE.
- `start` in SCAN or DONE is ignored and not queued.
- Config inputs are don't-care except in the cycle `start` is accepted; changes mid-frame have no effect.
- `match_count` and `sat` hold their values after DONE until the next accepted `start`.
- `rst` at any time: state IDLE; all outputs, history, fill and remaining cleared; any frame in progress is abandoned without `done`.

## Timing
- Reset values: `busy`=0, `match`=0, `done`=0, `match_count`=0, `sat`=0.
- `start` accepted at edge N: `busy`=1 from N+1.
- Bit accepted at edge N:
  - A hit gives `match`=1 during cycle N+1.
  - `match_count` shows the updated value from N+1.
- Last bit accepted at edge N:
  - `done`=1 during N+1, coincident with `match` if that bit hit.
  - `busy`=0 from N+2.
  - Earliest next `start` acceptance is at edge N+2.
- `cfg_frame`=0: `start` at edge N gives `done` during N+1 and `match_count`=0.
- Throughput: one bit per cycle, back-to-back `bit_valid`, no bubbles.

## Test plan
- Pattern 4'b1101, len 4, overlap=1, frame 7, stream 1,1,0,1,1,0,1 -> `match` after bits 4 and 7; `match_count`=2; `done` coincident with the second `match`.
- Same stream with overlap=0 -> single `match` after bit 4; `match_count`=1.
- CNT_W=2, len 1, pattern 1, frame 5, all ones -> `match_count` stops at 3; `sat`=1; 5 `match` pulses; `done` after bit 5.
- Random `bit_valid` gaps (0-5 idle cycles) on the first scenario -> identical match pattern and count; `start` pulsed mid-SCAN is ignored.
- `cfg_frame`=0 -> `done` one cycle after `start`; count 0. Also `cfg_len`=0 with pattern 1 behaves as len 1.
- Assert `rst` after 3 bits of a 7-bit frame -> next cycle all outputs 0, IDLE; no `done`. A fresh `start` then runs a normal frame.
